// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/dec3to8_case.sv
// 3-to-8 decoder with enable; all outputs low when disabled.
module dec3to8_case (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  // One-hot decode of sel, gated by en
  always_comb begin
    y = 8'h00;
    if (en) begin
      case (sel)
        3'd0:    y = 8'h01;
        3'd1:    y = 8'h02;
        3'd2:    y = 8'h04;
        3'd3:    y = 8'h08;
        3'd4:    y = 8'h10;
        3'd5:    y = 8'h20;
        3'd6:    y = 8'h40;
        3'd7:    y = 8'h80;
        default: y = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/rr_pick8.sv
// Round-robin pick: first set request at or after ptr, wrapping mod 8.
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   rel_idx;

  // Rotating right by ptr puts requester ptr at bit 0
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: N_REQ];

  // Fixed-priority encoder on the rotated vector, lowest bit wins
  always_comb begin
    rel_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) rel_idx = IDX_W'(i);
    end
  end

  // Undo the rotation; 3-bit add wraps mod 8
  assign pick_idx = rel_idx + ptr;
  assign pick_vld = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with done/req-drop release and hold timeout.
//
// state    | meaning
// ST_IDLE  | no grant; arbitrate on current req (the mandatory bubble cycle)
// ST_GRANT | gnt_idx owns the resource; hold_cnt counts its cycles
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout,
  output logic [CNT_W-1:0] hold_cnt
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             tmo_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             own_done;
  logic             own_req;
  logic             at_limit;

  rr_pick8 u_pick (
    .req      (req),
    .ptr      (ptr),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  assign own_done = done[gnt_idx];
  assign own_req  = req[gnt_idx];
  assign at_limit = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // State, pointer, grant index, hold counter and timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= idx_nxt;
      hold_cnt <= cnt_nxt;
      timeout  <= tmo_nxt;
    end
  end

  // Next-state: arbitrate in IDLE, release on done, req drop or hold limit
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    cnt_nxt   = hold_cnt;
    tmo_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (pick_vld) begin
          idx_nxt   = pick_idx;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (own_done || !own_req || at_limit) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = gnt_idx + 1'b1;
          cnt_nxt   = '0;
          // timeout only when the limit alone forced the release
          tmo_nxt   = at_limit && !own_done && own_req;
        end else if (hold_cnt != '1) begin
          cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign gnt_vld = (state == ST_GRANT);

  dec3to8_case u_dec (
    .en  (gnt_vld),
    .sel (gnt_idx),
    .y   (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8 (MAX_HOLD = 15).
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;
  logic [7:0] hold_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  rr_arbiter8 #(.MAX_HOLD(15), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_vld  (gnt_vld),
    .timeout  (timeout),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    req  = 8'h00;
    done = 8'h00;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      cyc();
      chk_cnt++;
      if (gnt !== 8'h00 || gnt_vld !== 1'b0 || hold_cnt !== 8'd0 || timeout !== 1'b0) begin
        $display("FAIL reset_idle c=%0d: gnt=%h vld=%b hold=%0d tmo=%b, want 00/0/0/0",
                 c, gnt, gnt_vld, hold_cnt, timeout);
      end else pass_cnt++;
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 8'b0000_0100;
    cyc();
    for (int c = 0; c < 4; c++) begin
      chk_cnt++;
      if (gnt !== 8'b0000_0100 || gnt_idx !== 3'd2 || gnt_vld !== 1'b1 || hold_cnt !== 8'(c)) begin
        $display("FAIL single_grant c=%0d: gnt=%h idx=%0d vld=%b hold=%0d, want 04/2/1/%0d",
                 c, gnt, gnt_idx, gnt_vld, hold_cnt, c);
      end else pass_cnt++;
      if (c == 3) done = 8'b0000_0100;
      cyc();
    end
    done = 8'h00;
    chk_cnt++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || timeout !== 1'b0 || hold_cnt !== 8'd0) begin
      $display("FAIL single_bubble: gnt=%h vld=%b tmo=%b hold=%0d, want 00/0/0/0",
               gnt, gnt_vld, timeout, hold_cnt);
    end else pass_cnt++;
    cyc();
    chk_cnt++;
    if (gnt !== 8'b0000_0100 || gnt_idx !== 3'd2 || hold_cnt !== 8'd0) begin
      $display("FAIL single_regrant: gnt=%h idx=%0d hold=%0d, want 04/2/0", gnt, gnt_idx, hold_cnt);
    end else pass_cnt++;
    req = 8'h00;
    cyc();
  endtask

  task automatic test_fairness();
    logic [2:0] exp_idx;
    logic [7:0] exp_gnt;
    apply_reset();
    req = 8'hFF;
    cyc();
    for (int k = 0; k < 9; k++) begin
      exp_idx = 3'(k % 8);
      exp_gnt = 8'h01 << exp_idx;
      chk_cnt++;
      if (gnt !== exp_gnt || gnt_idx !== exp_idx || gnt_vld !== 1'b1) begin
        $display("FAIL fair_grant k=%0d: gnt=%h idx=%0d vld=%b, want %h/%0d/1",
                 k, gnt, gnt_idx, gnt_vld, exp_gnt, exp_idx);
      end else pass_cnt++;
      cyc();
      done = exp_gnt;
      cyc();
      done = 8'h00;
      chk_cnt++;
      if (gnt !== 8'h00 || gnt_vld !== 1'b0) begin
        $display("FAIL fair_bubble k=%0d: gnt=%h vld=%b, want 00/0", k, gnt, gnt_vld);
      end else pass_cnt++;
      cyc();
    end
    req = 8'h00;
    cyc();
    cyc();
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 8'b1000_0001;
    cyc();
    for (int c = 0; c < 15; c++) begin
      chk_cnt++;
      if (gnt !== 8'h01 || gnt_idx !== 3'd0 || hold_cnt !== 8'(c) || timeout !== 1'b0) begin
        $display("FAIL tmo_hold c=%0d: gnt=%h idx=%0d hold=%0d tmo=%b, want 01/0/%0d/0",
                 c, gnt, gnt_idx, hold_cnt, timeout, c);
      end else pass_cnt++;
      cyc();
    end
    chk_cnt++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || timeout !== 1'b1 || hold_cnt !== 8'd0) begin
      $display("FAIL tmo_release: gnt=%h vld=%b tmo=%b hold=%0d, want 00/0/1/0",
               gnt, gnt_vld, timeout, hold_cnt);
    end else pass_cnt++;
    cyc();
    chk_cnt++;
    if (gnt !== 8'h80 || gnt_idx !== 3'd7 || timeout !== 1'b0) begin
      $display("FAIL tmo_next: gnt=%h idx=%0d tmo=%b, want 80/7/0", gnt, gnt_idx, timeout);
    end else pass_cnt++;
    req = 8'h00;
    cyc();
    cyc();
  endtask

  task automatic test_drop_stray();
    apply_reset();
    req = 8'b0000_1000;
    cyc();
    chk_cnt++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      $display("FAIL drop_grant: gnt=%h idx=%0d, want 08/3", gnt, gnt_idx);
    end else pass_cnt++;
    done = 8'b0010_0000;
    cyc();
    done = 8'h00;
    chk_cnt++;
    if (gnt !== 8'h08 || gnt_vld !== 1'b1 || hold_cnt !== 8'd1) begin
      $display("FAIL stray_done: gnt=%h vld=%b hold=%0d, want 08/1/1", gnt, gnt_vld, hold_cnt);
    end else pass_cnt++;
    req = 8'b0001_0001;
    cyc();
    chk_cnt++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
      $display("FAIL drop_release: gnt=%h vld=%b tmo=%b, want 00/0/0", gnt, gnt_vld, timeout);
    end else pass_cnt++;
    cyc();
    chk_cnt++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
      $display("FAIL drop_ptr: gnt=%h idx=%0d, want 10/4", gnt, gnt_idx);
    end else pass_cnt++;
    req = 8'h00;
    cyc();
    cyc();
  endtask

  task automatic test_rst_mid();
    apply_reset();
    req = 8'b0100_0000;
    cyc();
    for (int c = 0; c < 5; c++) cyc();
    chk_cnt++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6 || hold_cnt !== 8'd5) begin
      $display("FAIL rstmid_pre: gnt=%h idx=%0d hold=%0d, want 40/6/5", gnt, gnt_idx, hold_cnt);
    end else pass_cnt++;
    req = 8'b0100_0001;
    #2;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (gnt !== 8'h00 || gnt_vld !== 1'b0 || gnt_idx !== 3'd0 || hold_cnt !== 8'd0 || timeout !== 1'b0) begin
      $display("FAIL rstmid_async: gnt=%h vld=%b idx=%0d hold=%0d tmo=%b, want 00/0/0/0/0",
               gnt, gnt_vld, gnt_idx, hold_cnt, timeout);
    end else pass_cnt++;
    cyc();
    rst = 1'b0;
    cyc();
    chk_cnt++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_vld !== 1'b1) begin
      $display("FAIL rstmid_after: gnt=%h idx=%0d vld=%b, want 01/0/1", gnt, gnt_idx, gnt_vld);
    end else pass_cnt++;
    req = 8'h00;
    cyc();
    cyc();
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 8'h00;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_drop_stray();
    test_rst_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-way round-robin arbiter that shares one resource between 8 requesters.
- Selects one requester and holds the grant until release or timeout, then rotates priority.
- Grant is carried as a 3-bit index plus valid. The one-hot grant vector is produced by the team's 3-to-8 enable decoder (dec3to8_case) with en = gnt_vld.
- Sits between requester logic and any shared 8-way-selected resource, e.g. a bus or a display digit.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 to match the 3-to-8 decoder; other values unsupported.
- IDX_W, 3, index width, log2(N_REQ).
- MAX_HOLD, 15, maximum grant length in cycles before forced release; legal range 1..255.
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req  input  8  request per requester; level-sensitive, held until served.
- done  input  8  release pulse per requester; only done[gnt_idx] is honoured while granted.
- gnt  output  8  one-hot grant, all zero when gnt_vld=0.
- gnt_idx  output  3  index of the granted requester.
- gnt_vld  output  1  grant active.
- timeout  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.
- hold_cnt  output  CNT_W  cycles elapsed in the current grant.

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, hold_cnt=0.
- State IDLE:
  - If req==0, stay in IDLE.
  - Else pick the first set req bit searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - Register the pick into gnt_idx, set gnt_vld=1, hold_cnt=0, go to GRANT.
  - Latency: req sampled at edge k gives gnt visible after edge k (1-cycle registered).
- State GRANT:
  - hold_cnt increments by 1 each cycle.
  - Release condition, evaluated each cycle: done[gnt_idx]=1, OR req[gnt_idx]=0, OR hold_cnt==MAX_HOLD-1.
  - On release: gnt_vld=0, ptr=gnt_idx+1 (7 wraps to 0), hold_cnt=0, go to IDLE.
  - timeout=1 for that one cycle only when the hold limit caused the release and no done/req-drop occurred the same cycle.
  - Grant duration is therefore at most MAX_HOLD cycles.
- Mandatory bubble: after every release, gnt is 0 for exactly one cycle (the IDLE cycle) before the next grant. Every requester switch shows an all-zero gnt cycle.
- done bits for non-granted indices are ignored. done asserted in IDLE is ignored.
- The granted requester may re-win only after all other active requesters have been served, because ptr has moved past it.
- Simultaneous release and re-request: the same cycle's req is not used. The next arbitration uses req as sampled in the IDLE cycle.
- rst asserted mid-grant: immediate return to the reset state. No timeout pulse, ptr returns to 0.
- Invariants: gnt == (gnt_vld ? 1<<gnt_idx : 0); popcount(gnt) <= 1 always.
- hold_cnt saturates; it never wraps because of the MAX_HOLD release.

Decomposition:
- Shared package/include holds:
  - State encoding: ST_IDLE=1'b0, ST_GRANT=1'b1.
  - Constants N_REQ=8, IDX_W=3.
- Sub-module rr_pick8 (combinational): inputs req[7:0] and ptr[2:0]; outputs pick_idx[2:0] and pick_vld. Implementation is rotate right by ptr, then a fixed-priority encoder, then add ptr mod 8.
- Top-level rr_arbiter8 contains:
  - the FSM, ptr, hold counter and timeout;
  - one rr_pick8 instance;
  - one dec3to8_case instance for gnt.

Test Plan:
- Reset/idle: rst=1 mid-run, then req=0 for 10 cycles -> gnt=0, gnt_vld=0, ptr=0, hold_cnt=0 throughout.
- Single requester: req=8'b0000_0100, done[2] pulsed on the 4th grant cycle -> gnt=8'b0000_0100 from cycle k+1, released after 4 cycles, one bubble cycle, then re-granted to index 2.
- Fairness: req=8'hFF held, each holder pulses done after 2 cycles -> grant order 0,1,2,...,7,0, one bubble cycle between each, ptr wraps 7->0.
- Timeout: MAX_HOLD=15, req=8'b1000_0000 and 8'b0000_0001 held, no done -> idx 0 granted 15 cycles, timeout=1 on the release cycle, bubble, then idx 7 granted.
- Req drop and stray done: idx 3 granted, done[5] pulsed (ignored), then req[3] deasserted -> release next edge, timeout=0, ptr=4.
- Reset mid-grant: idx 6 granted with hold_cnt=5, rst pulsed -> all outputs 0 immediately; after rst release with req=8'b0100_0001 -> idx 0 granted first.
